nonce_range_down: RTL

Loadable down-counting nonce dispenser for the miner datapath. Accepts a base nonce and a count over a load handshake. Emits `count` nonces, starting at the base and decrementing modulo 2^WIDTH, over a valid/ready stream toward a hashing core. It is the consumer-side complement of the free-running up counters used for phase sequencing: it counts down to a terminal value and signals completion.

---
 rtl/nonce_range_down.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nonce_range_down.sv
// -----------------------------------------------------------------------------
// nonce_range_down
//
// Loadable down-counting nonce dispenser for the miner datapath. A range
// (base, count) is accepted over a load handshake. The block then emits
// base, base-1, ..., base-count+1 (modulo 2^WIDTH) over a valid/ready stream
// toward a hashing core, and pulses done for one cycle when the range finishes.
// A count of zero completes immediately, without any stream traffic.
//
// Optional feature macro: NONCE_DOWN_STATS_EN
//   When defined, adds the `emitted` output. It counts transfers since the
//   last accepted load, and abort does not clear it.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   abort       in   cancels any range in progress (priority below reset)
//   load_valid  in   a range is offered
//   load_ready  out  range can be accepted (IDLE and no abort)
//   load_base   in   [WIDTH] first nonce to emit
//   load_count  in   [WIDTH] number of nonces to emit (0 legal)
//   out_valid   out  out_nonce is valid (RUN)
//   out_ready   in   downstream accepts the nonce
//   out_nonce   out  [WIDTH] current nonce
//   busy        out  high in RUN
//   done        out  one-cycle pulse on normal completion
//   emitted     out  [WIDTH] transfers since last load (NONCE_DOWN_STATS_EN)
// -----------------------------------------------------------------------------
module nonce_range_down #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             abort,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_base,
    input  logic [WIDTH-1:0] load_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_nonce,
    output logic             busy,
`ifdef NONCE_DOWN_STATS_EN
    output logic [WIDTH-1:0] emitted,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] nonce_q, nonce_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
`ifdef NONCE_DOWN_STATS_EN
    logic [WIDTH-1:0] emitted_q, emitted_d;
`endif

    // Outputs are decoded from state only. The single exception is abort,
    // which masks load_ready so a load offered alongside abort is refused.
    assign out_valid  = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign load_ready = (state_q == ST_IDLE) && !abort;
    assign out_nonce  = nonce_q;
`ifdef NONCE_DOWN_STATS_EN
    assign emitted    = emitted_q;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case statement can leave a variable unassigned and infer a latch.
        state_d     = state_q;
        nonce_d     = nonce_q;
        remaining_d = remaining_q;
`ifdef NONCE_DOWN_STATS_EN
        emitted_d   = emitted_q;
`endif

        if (abort) begin
            // Abort wins over load and transfer. Nothing is counted this cycle.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        nonce_d     = load_base;
                        remaining_d = load_count;
`ifdef NONCE_DOWN_STATS_EN
                        emitted_d   = '0;
`endif
                        state_d     = (load_count == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        nonce_d     = nonce_q - WIDTH'(1);
                        remaining_d = remaining_q - WIDTH'(1);
`ifdef NONCE_DOWN_STATS_EN
                        emitted_d   = emitted_q + WIDTH'(1);
`endif
                        if (remaining_q == WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge, so it is not in the
        // sensitivity list. Every register, datapath included, is cleared,
        // because out_nonce must read zero after reset.
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // flops update together from the values they held before the edge.
            state_q     <= ST_IDLE;
            nonce_q     <= '0;
            remaining_q <= '0;
`ifdef NONCE_DOWN_STATS_EN
            emitted_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            nonce_q     <= nonce_d;
            remaining_q <= remaining_d;
`ifdef NONCE_DOWN_STATS_EN
            emitted_q   <= emitted_d;
`endif
        end
    end

endmodule
